// File: rtl/seven_seg_pkg.sv
// Shared types and the hex-to-segment encoding for the seven_seg_scan display back end.
// Segment vectors are {g,f,e,d,c,b,a} and active-low.
package seven_seg_pkg;

   localparam int DIGITS = 4;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'b111_1111;

   function automatic seg_t hex_to_seg(input logic [3:0] nib);
      seg_t s;
      case (nib)
         4'h0:    s = 7'b100_0000;
         4'h1:    s = 7'b111_1001;
         4'h2:    s = 7'b010_0100;
         4'h3:    s = 7'b011_0000;
         4'h4:    s = 7'b001_1001;
         4'h5:    s = 7'b001_0010;
         4'h6:    s = 7'b000_0010;
         4'h7:    s = 7'b111_1000;
         4'h8:    s = 7'b000_0000;
         4'h9:    s = 7'b001_0000;
         4'hA:    s = 7'b000_1000;
         4'hB:    s = 7'b000_0011;
         4'hC:    s = 7'b100_0110;
         4'hD:    s = 7'b010_0001;
         4'hE:    s = 7'b000_0110;
         4'hF:    s = 7'b000_1110;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seven_seg_timebase.sv
// Slot/phase timebase for seven_seg_scan: tick counts 0..DIV-1, digit 0..3, phase 0..7.
// A separate per-phase counter avoids a divider when deriving the phase from tick.
module seven_seg_timebase #(
   parameter int DIV = 80
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] digit,
   output logic [2:0] phase,
   output logic       slot_start,
   output logic       frame_end
);

   localparam int PH     = DIV / 8;
   localparam int TICK_W = $clog2(DIV);
   localparam int PH_W   = $clog2(PH);
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);
   localparam logic [PH_W-1:0]   PH_MAX   = PH_W'(PH - 1);

   if (((DIV % 8) != 0) || (DIV < 16)) begin : g_bad_div
      $error("seven_seg_timebase: DIV must be a multiple of 8 and at least 16");
   end

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
   logic [2:0]        phase_q, phase_d;
   logic [1:0]        digit_q, digit_d;
   logic              tick_wrap_s;
   logic              ph_wrap_s;

   // Next-state for the slot, phase and digit counters
   always_comb begin
      tick_wrap_s = (tick_q == TICK_MAX);
      ph_wrap_s   = (ph_cnt_q == PH_MAX);
      if (tick_wrap_s) begin
         tick_d  = '0;
         digit_d = digit_q + 2'd1;
      end else begin
         tick_d  = tick_q + TICK_W'(1);
         digit_d = digit_q;
      end
      // DIV is exactly 8*PH, so phase rolls 7->0 on the same cycle tick wraps
      if (ph_wrap_s) begin
         ph_cnt_d = '0;
         phase_d  = phase_q + 3'd1;
      end else begin
         ph_cnt_d = ph_cnt_q + PH_W'(1);
         phase_d  = phase_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q   <= '0;
         ph_cnt_q <= '0;
         phase_q  <= 3'd0;
         digit_q  <= 2'd0;
      end else begin
         tick_q   <= tick_d;
         ph_cnt_q <= ph_cnt_d;
         phase_q  <= phase_d;
         digit_q  <= digit_d;
      end
   end

   assign digit      = digit_q;
   assign phase      = phase_q;
   assign slot_start = (tick_q == '0);
   assign frame_end  = (digit_q == 2'd3) && tick_wrap_s;

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode 7-segment driver with PWM brightness and guard phase.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_BLANK_EN.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 4_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic [2:0]  brightness,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   localparam int DIV = CLK_HZ / REFRESH_HZ;

   logic [1:0]        digit_s;
   logic [2:0]        phase_s;
   logic              slot_start_s;
   logic              frame_end_s;

   logic [15:0]       shadow_q, shadow_d;
   logic [3:0]        dp_shadow_q, dp_shadow_d;
   logic [2:0]        bright_q, bright_d;
   seg_t              seg_q, seg_d;
   logic              dp_q, dp_d;
   logic [3:0]        an_q, an_d;

   logic [3:0]        cur_nib_s;
   logic [DIGITS-1:0] unblank_s;
   logic              digit_on_s;

   seven_seg_timebase #(
      .DIV (DIV)
   ) u_timebase (
      .clk        (clk),
      .rst_n      (rst_n),
      .digit      (digit_s),
      .phase      (phase_s),
      .slot_start (slot_start_s),
      .frame_end  (frame_end_s)
   );

`ifdef SEVEN_SEG_BLANK_EN
   // A digit stays lit when it or any more significant nibble is non-zero; digit 0 always lit
   always_comb begin
      unblank_s[0] = 1'b1;
      unblank_s[1] = |shadow_q[15:4];
      unblank_s[2] = |shadow_q[15:8];
      unblank_s[3] = |shadow_q[15:12];
   end
`else
   assign unblank_s = 4'b1111;
`endif

   // Frame/slot latches and the next output values derived from the current counter state
   always_comb begin
      shadow_d    = frame_end_s  ? value      : shadow_q;
      dp_shadow_d = frame_end_s  ? dp_mask    : dp_shadow_q;
      bright_d    = slot_start_s ? brightness : bright_q;

      cur_nib_s  = shadow_q[{digit_s, 2'b00} +: 4];
      digit_on_s = unblank_s[digit_s];

      // Segments only change under the guard phase, while every anode is off
      if (phase_s == 3'd0) begin
         seg_d = hex_to_seg(cur_nib_s);
         dp_d  = ~(dp_shadow_q[digit_s] & digit_on_s);
      end else begin
         seg_d = seg_q;
         dp_d  = dp_q;
      end

      an_d = 4'b1111;
      if ((phase_s != 3'd0) && (phase_s <= bright_q) && digit_on_s) begin
         an_d[digit_s] = 1'b0;
      end else begin
         an_d = 4'b1111;
      end
   end

   // Shadow, brightness and output registers; reset forces the display dark immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q    <= 16'h0000;
         dp_shadow_q <= 4'b0000;
         bright_q    <= 3'd0;
         seg_q       <= SEG_OFF;
         dp_q        <= 1'b1;
         an_q        <= 4'b1111;
      end else begin
         shadow_q    <= shadow_d;
         dp_shadow_q <= dp_shadow_d;
         bright_q    <= bright_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan at CLK_HZ=800, REFRESH_HZ=10 (DIV=80, PH=10).
// Expected frames are queued when inputs are driven and checked slot by slot when displayed.
module tb_seven_seg_scan;

   localparam int DIV   = 80;
   localparam int PH    = 10;
   localparam int FRAME = 4 * DIV;
   localparam int NV    = 7;

`ifdef SEVEN_SEG_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic [2:0]  brightness;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp_mask;
      logic [2:0]  bright;
      logic [27:0] exp_seg;   // {digit3, digit2, digit1, digit0}
      logic [3:0]  blank_ub;  // digits that stay lit when leading-zero blanking is on
   } vec_t;

   typedef struct {
      logic [27:0] seg;
      logic [3:0]  dp;
      logic [3:0]  ub;
      logic [2:0]  bright;
   } exp_t;

   vec_t tbl [NV];
   exp_t sb_q [$];

   localparam logic [27:0] SEG_ZEROS = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

   seven_seg_scan #(
      .CLK_HZ     (800),
      .REFRESH_HZ (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dp_mask    (dp_mask),
      .brightness (brightness),
      .seg        (seg),
      .dp         (dp),
      .an         (an)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk_exp(input logic [27:0] s, input logic [3:0] dpm,
                                   input logic [3:0] ub_blank, input logic [2:0] b);
      exp_t e;
      e.seg    = s;
      e.ub     = BLANK_ON ? ub_blank : 4'b1111;
      e.dp     = ~(dpm & e.ub);
      e.bright = b;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Observes one full frame (320 output cycles), optionally driving the next vector mid-frame
   task automatic run_frame(input int f);
      exp_t e;
      int   lit [4];
      bit   seg_bad [4];
      bit   dp_bad [4];
      bit   stray [4];
      for (int i = 0; i < 4; i++) begin
         lit[i] = 0; seg_bad[i] = 1'b0; dp_bad[i] = 1'b0; stray[i] = 1'b0;
      end
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 1, 0);
         e = mk_exp(SEG_ZEROS, 4'b0000, 4'b1111, 3'd0);
      end else begin
         e = sb_q.pop_front();
      end
      for (int t = 0; t < FRAME; t++) begin
         int         d;
         int         tk;
         int         ph;
         logic [3:0] on_an;
         logic [6:0] es;
         @(negedge clk);
         d  = t / DIV;
         tk = t % DIV;
         ph = tk / PH;
         on_an    = 4'b1111;
         on_an[d] = 1'b0;
         es = e.seg[7*d +: 7];
         if (seg !== es) seg_bad[d] = 1'b1;
         if (dp !== e.dp[d]) dp_bad[d] = 1'b1;
         if (an === on_an) begin
            lit[d]++;
            if (!((ph >= 1) && (ph <= int'(e.bright)) && e.ub[d])) stray[d] = 1'b1;
         end else if (an !== 4'b1111) begin
            stray[d] = 1'b1;
         end
         if ((f >= 1) && (f < NV)) begin
            if (t == 100) begin
               value   = tbl[f].value;
               dp_mask = tbl[f].dp_mask;
               sb_q.push_back(mk_exp(tbl[f].exp_seg, tbl[f].dp_mask, tbl[f].blank_ub, tbl[f].bright));
            end
            if (t == 300) brightness = tbl[f].bright;
         end
         if (tk == DIV - 1) begin
            check($sformatf("f%0d_slot%0d_seg_wrong", f, d), int'(seg_bad[d]), 0);
            check($sformatf("f%0d_slot%0d_dp_wrong", f, d), int'(dp_bad[d]), 0);
            check($sformatf("f%0d_slot%0d_lit_cycles", f, d), lit[d],
                  e.ub[d] ? PH * int'(e.bright) : 0);
            check($sformatf("f%0d_slot%0d_bad_anode", f, d), int'(stray[d]), 0);
         end
      end
   endtask

   initial begin
      tbl[0] = '{16'h1234, 4'b0000, 3'd7,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
      tbl[1] = '{16'hABCD, 4'b0010, 3'd7,
                 {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b1111};
      tbl[2] = '{16'h1234, 4'b0000, 3'd0,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
      tbl[3] = '{16'h0005, 4'b0001, 3'd3,
                 {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010}, 4'b0001};
      tbl[4] = '{16'h0000, 4'b1110, 3'd7, SEG_ZEROS, 4'b0001};
      tbl[5] = '{16'hF0E9, 4'b1001, 3'd5,
                 {7'b0001110, 7'b1000000, 7'b0000110, 7'b0010000}, 4'b1111};
      tbl[6] = '{16'h0870, 4'b1111, 3'd1,
                 {7'b1000000, 7'b0000000, 7'b1111000, 7'b1000000}, 4'b0111};

      value      = tbl[0].value;
      dp_mask    = tbl[0].dp_mask;
      brightness = tbl[0].bright;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_an", int'(an), 32'hF);
      check("reset_seg", int'(seg), 32'h7F);
      check("reset_dp", int'(dp), 1);

      // Frame 0 shows the reset shadow; the initial inputs appear in frame 1
      sb_q.push_back(mk_exp(SEG_ZEROS, 4'b0000, 4'b0001, 3'd7));
      sb_q.push_back(mk_exp(tbl[0].exp_seg, tbl[0].dp_mask, tbl[0].blank_ub, tbl[0].bright));
      rst_n = 1'b1;
      for (int f = 0; f <= NV; f++) begin
         run_frame(f);
      end

      // Asynchronous reset mid-slot: slot 1, phase 1, showing digit '7' of 0870
      repeat (96) @(negedge clk);
      check("pre_reset_an", int'(an), 32'hD);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_an", int'(an), 32'hF);
      check("async_reset_seg", int'(seg), 32'h7F);
      check("async_reset_dp", int'(dp), 1);
      repeat (2) @(negedge clk);
      sb_q.push_back(mk_exp(SEG_ZEROS, 4'b0000, 4'b0001, 3'd1));
      rst_n = 1'b1;
      run_frame(NV + 1);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Display back end for the CPU's memory-mapped 16-bit `display_out` register. It latches the word once per refresh frame and time-multiplexes it as four hex digits onto a common-anode 7-segment display. It provides PWM brightness, per-digit decimal points and anti-ghosting guard intervals. It sits between the CPU top level and the board pins and is driven purely by `clk`, not by the CPU's clock enable.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: input clock frequency.
- `REFRESH_HZ`, 4_000: digit slot rate; a frame is 4 slots.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `value` in 16: word to display, taken from CPU `display_out`.
- `dp_mask` in 4: decimal point enable per digit; bit i maps to digit i.
- `brightness` in 3: 0 is dark, 7 is maximum (7/8 duty).
- `seg` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 4: digit anodes, active-low; `an[0]` is the rightmost digit.

## Operation
- **Slot length.** `DIV = CLK_HZ/REFRESH_HZ`. `DIV` must be a multiple of 8 and at least 16; otherwise elaboration fails via `$error`.
- **Phase.** `PH = DIV/8`. Each slot is split into 8 phases of `PH` cycles.
- **Counters.** `tick` counts 0..DIV-1. `digit` counts 0..3 and advances when `tick` wraps; digit 3 wraps to 0.
- **Frame latch.** When `digit==3 && tick==DIV-1`, latch `shadow <= value` and `dp_shadow <= dp_mask`. Input changes mid-frame never affect the current frame, so there is no tearing.
- **Slot start.** When `tick==0`, latch `bright_q <= brightness`.
- **Segments.** `seg` and `dp` update only during phase 0 (the guard phase).
  - `seg` is the hex encoding of nibble `shadow[4*digit +: 4]`.
  - `dp` is `~dp_shadow[digit]`.
- **Anode.** `an[digit]` is low when `1 <= phase <= bright_q` and the digit is not blanked. All other anodes are high.
  - Phase 0 always has every anode off.
  - `brightness==0` means the display is permanently dark.
- **Encoding.** Active-low, `{g..a}`: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Reset.** On reset (async, including mid-frame), every output goes to its off value immediately:
  - `an=4'b1111`, `seg=7'b1111111`, `dp=1`.
  - `tick=0`, `digit=0`, `shadow=0`, `dp_shadow=0`, `bright_q=0`.
- **After reset.** The first frame displays the reset `shadow`, i.e. 0000. `value` is first sampled at the end of frame 0.

## Timing
- All outputs are registered, 1 cycle behind the counter state. Example: counter at `tick==PH` (phase 1, digit d) produces `an[d]` low on the next edge.
- Frame period is `4*DIV` cycles.
- `value` to display latency is between 1 and `4*DIV` cycles, depending on frame position at the time of change.
- `brightness` takes effect at the next slot start.
- Latch and wrap on the same cycle: `shadow` loads and `digit` goes 3→0 on the same edge. Digit 0 of the new frame uses the new `shadow`.

## Configuration
- `SEVEN_SEG_BLANK_EN` defined: leading-zero blanking.
  - Digits above the most significant non-zero nibble of `shadow` keep their anode high for the whole slot.
  - Digit 0 is never blanked, so 0x0000 shows a single "0".
  - The decimal point of a blanked digit is also dark.
- Macro undefined: all four digits are always driven.

## Structure
- Package `seven_seg_pkg`:
  - `localparam DIGITS=4`.
  - `typedef logic [6:0] seg_t`.
  - `SEG_OFF` constant.
  - Function `hex_to_seg(logic [3:0]) -> seg_t` holding the encoding table.
- One sub-module, `seven_seg_timebase`. It owns `tick`, `digit` and `phase` and emits `slot_start`, `frame_end` and `phase` pulses/values.
- The top level holds the shadow registers, the blanking logic and the output registers.

## Test plan
Parameters for all scenarios: `CLK_HZ=800`, `REFRESH_HZ=10`, giving `DIV=80` and `PH=10`.
- **Basic scan.** `value=16'h1234`, `brightness=7`, run 2 frames.
  - Frame 0 shows 0000.
  - Frame 1, slot 0: `an=4'b1110` for 70 cycles with `seg=7'b0011001`, and `an=1111` for 10 guard cycles.
  - Frame 1, slot 3: `seg=7'b1111001`.
- **Mid-frame change.** Change `value` from 1234 to ABCD during slot 1.
  - Slots 2 and 3 still show 2 and 1.
  - The next frame shows D, C, b, A (`seg` = 0100001, 1000110, 0000011, 0001000).
- **Brightness.** `brightness=0`: `an` stays 1111 for a full frame. `brightness=3`: each active anode is low for exactly 30 cycles per slot, in phases 1–3.
- **Decimal point.** `dp_mask=4'b0010`: `dp` is low only in slot 1 and high in every other slot.
- **Blanking with macro.** `value=16'h0005`: `an[3:1]` never go low. `value=0`: only `an[0]` is active, with `seg=7'b1000000`.
- **Blanking without macro.** Same stimulus: all 4 digits are lit.
- **Reset.** Assert `rst_n=0` mid-slot: `an=1111`, `seg=7'b1111111`, `dp=1` within the same cycle with no clock edge. After release, `digit` restarts at 0 and the display shows 0000.
